// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, default sizing and control-word bit positions.
// Datapath blocks import this package so everyone agrees on the control-word layout.
package cpu_defs;

  localparam int DEF_NUM_STEPS     = 5;
  localparam int DEF_OPERAND_WIDTH = 4;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  // II, IO, FI and HLT stay internal to the control unit; the rest are ports.
  localparam int CW_LOAD_A    = 0;
  localparam int CW_LOAD_B    = 1;
  localparam int CW_WRITE_A   = 2;
  localparam int CW_WRITE_ALU = 3;
  localparam int CW_SUBTRACT  = 4;
  localparam int CW_MI        = 5;
  localparam int CW_RO        = 6;
  localparam int CW_RI        = 7;
  localparam int CW_CO        = 8;
  localparam int CW_CE        = 9;
  localparam int CW_J         = 10;
  localparam int CW_OI        = 11;
  localparam int CW_II        = 12;
  localparam int CW_IO        = 13;
  localparam int CW_FI        = 14;
  localparam int CW_HLT       = 15;
  localparam int CW_W         = 16;

  typedef enum logic {
    RUN_ST  = 1'b0,
    HALT_ST = 1'b1
  } run_state_t;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: (step, opcode, flags) -> control word.
// Fetch occupies T0/T1 for every opcode; execute lives in T2..T4.
module microcode_rom
  import cpu_defs::*;
#(
  parameter int STEP_W = 3
) (
  input  logic [STEP_W-1:0] step,
  input  logic [3:0]        opcode,
  input  logic              carry_flag,
  input  logic              zero_flag,
  output logic [CW_W-1:0]   cw
);

  logic t0, t1, t2, t3, t4;

  assign t0 = (32'(step) == 32'd0);
  assign t1 = (32'(step) == 32'd1);
  assign t2 = (32'(step) == 32'd2);
  assign t3 = (32'(step) == 32'd3);
  assign t4 = (32'(step) == 32'd4);

  always_comb begin
    cw = '0;
    if (t0) begin
      cw[CW_CO] = 1'b1;
      cw[CW_MI] = 1'b1;
    end else if (t1) begin
      cw[CW_RO] = 1'b1;
      cw[CW_II] = 1'b1;
      cw[CW_CE] = 1'b1;
    end else begin
      case (opcode)
        OP_LDA: begin
          if (t2) begin cw[CW_IO] = 1'b1; cw[CW_MI] = 1'b1; end
          if (t3) begin cw[CW_RO] = 1'b1; cw[CW_LOAD_A] = 1'b1; end
        end
        OP_ADD, OP_SUB: begin
          if (t2) begin cw[CW_IO] = 1'b1; cw[CW_MI] = 1'b1; end
          if (t3) begin cw[CW_RO] = 1'b1; cw[CW_LOAD_B] = 1'b1; end
          if (t4) begin
            cw[CW_WRITE_ALU] = 1'b1;
            cw[CW_LOAD_A]    = 1'b1;
            cw[CW_FI]        = 1'b1;
            cw[CW_SUBTRACT]  = (opcode == OP_SUB);
          end
        end
        OP_STA: begin
          if (t2) begin cw[CW_IO] = 1'b1; cw[CW_MI] = 1'b1; end
          if (t3) begin cw[CW_WRITE_A] = 1'b1; cw[CW_RI] = 1'b1; end
        end
        OP_LDI: if (t2) begin cw[CW_IO] = 1'b1; cw[CW_LOAD_A] = 1'b1; end
        OP_JMP: if (t2) begin cw[CW_IO] = 1'b1; cw[CW_J] = 1'b1; end
        // Untaken conditional jumps drive nothing, so the bus floats.
        OP_JC:  if (t2 && carry_flag) begin cw[CW_IO] = 1'b1; cw[CW_J] = 1'b1; end
        OP_JZ:  if (t2 && zero_flag) begin cw[CW_IO] = 1'b1; cw[CW_J] = 1'b1; end
        OP_OUT: if (t2) begin cw[CW_WRITE_A] = 1'b1; cw[CW_OI] = 1'b1; end
        OP_HLT: if (t2) cw[CW_HLT] = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// CPU control unit: owns IR, the microstep counter, ALU flags and the halt state,
// decodes them through microcode_rom and drives the IR operand onto the bus.
module control_unit
  import cpu_defs::*;
#(
  parameter int NUM_STEPS     = DEF_NUM_STEPS,
  parameter int OPERAND_WIDTH = DEF_OPERAND_WIDTH,
  localparam int STEP_W       = $clog2(NUM_STEPS)
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [7:0]        bus,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              load_A,
  output logic              load_B,
  output logic              write_A,
  output logic              write_ALU,
  output logic              subtract,
  output logic              MI,
  output logic              RO,
  output logic              RI,
  output logic              CO,
  output logic              CE,
  output logic              J,
  output logic              OI,
  output logic              halted,
  output logic [STEP_W-1:0] dbg_step,
  output logic [7:0]        dbg_ir,
  output logic              dbg_carry_flag,
  output logic              dbg_zero_flag,
  output logic              dbg_bus_oe
);

  run_state_t        state, state_next;
  logic [STEP_W-1:0] step, step_next;
  logic [7:0]        ir, ir_next;
  logic              carry_flag, carry_next;
  logic              zero_flag, zero_next;
  logic [CW_W-1:0]   rom_cw;
  logic [CW_W-1:0]   cw;
  logic [7:0]        operand_bus;

  microcode_rom #(.STEP_W(STEP_W)) u_microcode_rom (
    .step       (step),
    .opcode     (ir[7:4]),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .cw         (rom_cw)
  );

  assign halted = (state == HALT_ST);
  // Halt masks every control so the datapath sits idle until reset.
  assign cw     = halted ? '0 : rom_cw;

  always_comb begin
    state_next = state;
    step_next  = step;
    ir_next    = ir;
    carry_next = carry_flag;
    zero_next  = zero_flag;
    if (state == RUN_ST) begin
      step_next = (32'(step) == NUM_STEPS - 1) ? '0 : step + 1'b1;
      if (cw[CW_II]) ir_next = bus;
      if (cw[CW_FI]) begin
        carry_next = alu_carry;
        zero_next  = alu_zero;
      end
      if (cw[CW_HLT]) state_next = HALT_ST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN_ST;
      step       <= '0;
      ir         <= 8'h00;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      state      <= state_next;
      step       <= step_next;
      ir         <= ir_next;
      carry_flag <= carry_next;
      zero_flag  <= zero_next;
    end
  end

  // IO is the only step where this block drives the bus.
  assign operand_bus = 8'(ir[OPERAND_WIDTH-1:0]);
  assign bus         = cw[CW_IO] ? operand_bus : 8'bz;

  assign load_A    = cw[CW_LOAD_A];
  assign load_B    = cw[CW_LOAD_B];
  assign write_A   = cw[CW_WRITE_A];
  assign write_ALU = cw[CW_WRITE_ALU];
  assign subtract  = cw[CW_SUBTRACT];
  assign MI        = cw[CW_MI];
  assign RO        = cw[CW_RO];
  assign RI        = cw[CW_RI];
  assign CO        = cw[CW_CO];
  assign CE        = cw[CW_CE];
  assign J         = cw[CW_J];
  assign OI        = cw[CW_OI];

  assign dbg_step       = step;
  assign dbg_ir         = ir;
  assign dbg_carry_flag = carry_flag;
  assign dbg_zero_flag  = zero_flag;
  assign dbg_bus_oe     = cw[CW_IO];

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 5, microsteps per instruction (T0..T4).
REQ-002 SHALL have parameter OPERAND_WIDTH, default 4, IR operand/address field width.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 bus  inout  8  main bus; read for IR load, driven only when IO active, else high-Z.
REQ-006 alu_carry  input  1  ALU carry-out, sampled on FI.
REQ-007 alu_zero  input  1  ALU result-zero, sampled on FI.
REQ-008 load_A, load_B  output  1 each  A/B register load from bus.
REQ-009 write_A, write_ALU  output  1 each  A register / ALU result onto bus.
REQ-010 subtract  output  1  ALU subtract select.
REQ-011 MI, RO, RI  output  1 each  RAM address in, RAM out, RAM in.
REQ-012 CO, CE, J  output  1 each  PC out, PC count enable, PC jump load.
REQ-013 OI  output  1  output-display register load.
REQ-014 halted  output  1  CPU halted; clock-gating request to top level.

Function
REQ-015 State: IR[7:0], step counter (0..NUM_STEPS-1), carry_flag, zero_flag, halted register.
REQ-016 Control outputs SHALL be a combinational decode of (step, IR[7:4], flags, halted) only; no bus or ALU input reaches them combinationally.
REQ-017 Controls decoded in a cycle SHALL be sampled by all datapath blocks at the next rising clk; same edge advances step.
REQ-018 T0: CO MI. T1: RO II CE (II = internal IR load from bus on that edge).
REQ-019 Opcodes T2/T3/T4: NOP 0x0 none; LDA 0x1 IO MI / RO load_A; ADD 0x2 IO MI / RO load_B / write_ALU load_A FI; SUB 0x3 as ADD plus subtract in T4.
REQ-020 STA 0x4 IO MI / write_A RI; LDI 0x5 IO load_A; JMP 0x6 IO J; JC 0x7 IO J only if carry_flag; JZ 0x8 IO J only if zero_flag.
REQ-021 OUT 0xE: T2 write_A OI; HLT 0xF: T2 no controls, halted set at the T2->T3 edge.
REQ-022 Undefined opcodes 0x9-0xD SHALL behave as NOP.
REQ-023 Untaken JC/JZ SHALL assert no control and leave bus high-Z in T2.
REQ-024 IO SHALL drive bus = {4'b0, IR[3:0]}; at most one bus driver per step by construction.
REQ-025 FI SHALL latch carry_flag<=alu_carry, zero_flag<=alu_zero; flags otherwise hold.
REQ-026 Step SHALL wrap NUM_STEPS-1 -> 0 for every opcode (fixed-length instructions).
REQ-027 While halted: step and IR frozen, all control outputs 0, bus high-Z; only rst exits.

Reset
REQ-028 rst SHALL set IR=0x00, step=0, carry_flag=0, zero_flag=0, halted=0 on the next rising clk, overriding any in-progress step, II, FI or halt.
REQ-029 During/after reset outputs SHALL be the T0 word: CO=1, MI=1, all others 0, halted=0.

Structure
REQ-030 Opcode values, NUM_STEPS and control-word bit indices SHALL live in shared include cpu_defs.vh, also used by datapath blocks.
REQ-031 Decode SHALL be sub-module microcode_rom (combinational: step, opcode, flags -> control word); control_unit holds IR, step, flags, halted and bus driver (tri_state_buffer).

Verification
REQ-032 rst 2 cycles -> CO=MI=1; T1 with bus=0x1E -> IR=0x1E; T2 -> bus=0x0E, MI=1; T3 -> RO=1, load_A=1; T4 none; then step 0.
REQ-033 ADD (0x2F) with alu_carry=1, alu_zero=0 at T4 -> carry_flag=1; next JC 0x73 -> T2 J=1, bus=0x03.
REQ-034 JZ 0x85 with zero_flag=0 -> T2 all controls 0, bus high-Z, step advances to 3.
REQ-035 HLT 0xF0 -> halted=1 after T2 edge; 10 further clocks: step frozen, all controls 0; rst -> halted=0, CO=MI=1.
REQ-036 rst asserted in T3 of LDA -> next cycle step=0, IR=0x00, load_A not asserted.
REQ-037 Opcode 0xA5 -> T2..T4 all controls 0, bus high-Z, flags unchanged, wrap to T0.
